// File: rtl/sched_pkg.sv
// Shared constants, FSM state type and operand-dependency helper for the issue scheduler.
package sched_pkg;

    localparam int NUM_SLOTS = 4;

    localparam int OP_LO   = 6;
    localparam int SRC1_LO = 4;
    localparam int SRC2_LO = 2;
    localparam int DEST_LO = 0;

    localparam int DEF_LAT_OP0 = 1;
    localparam int DEF_LAT_OP1 = 1;
    localparam int DEF_LAT_OP2 = 2;
    localparam int DEF_LAT_OP3 = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        RETIRE = 2'd2
    } sched_state_e;

    // Operand fields only ({src1, src2, dest}); true on any RAW, WAW or WAR conflict.
    function automatic logic dependsOn(input logic [5:0] youngOps, input logic [5:0] oldOps);
        logic [1:0] ySrc1, ySrc2, yDest, oSrc1, oSrc2, oDest;
        ySrc1 = youngOps[SRC1_LO +: 2];
        ySrc2 = youngOps[SRC2_LO +: 2];
        yDest = youngOps[DEST_LO +: 2];
        oSrc1 = oldOps[SRC1_LO +: 2];
        oSrc2 = oldOps[SRC2_LO +: 2];
        oDest = oldOps[DEST_LO +: 2];
        return (oDest == ySrc1) || (oDest == ySrc2) || (oDest == yDest)
            || (oSrc1 == yDest) || (oSrc2 == yDest);
    endfunction

endpackage

// File: rtl/sched_hazard_check.sv
// Combinational hazard screen: a tracked slot is blocked by any older tracked slot it conflicts with.
module sched_hazard_check
    import sched_pkg::*;
(
    input  logic [NUM_SLOTS*8-1:0]              i_instr_flat,
    input  logic [NUM_SLOTS-1:0]                i_tracked,
    input  logic [NUM_SLOTS-1:0][NUM_SLOTS-1:0] i_older,
    output logic [NUM_SLOTS-1:0]                o_blocked
);

    logic [NUM_SLOTS*2-1:0] w_unused_ops;

    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_ops
        assign w_unused_ops[2*k +: 2] = i_instr_flat[8*k + OP_LO +: 2];
    end

    always_comb begin
        o_blocked = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            for (int j = 0; j < NUM_SLOTS; j++) begin
                if (i != j && i_tracked[i] && i_tracked[j] && i_older[i][j]
                    && dependsOn(i_instr_flat[8*i +: 6], i_instr_flat[8*j +: 6])) begin
                    o_blocked[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/instr_issue_scheduler.sv
// Single-issue, oldest-first scheduler with one multi-cycle execution unit.
// Optional performance counters are enabled by defining SCHED_PERF_CNT_EN.
module instr_issue_scheduler
    import sched_pkg::*;
#(
    parameter int LAT_OP0 = DEF_LAT_OP0,
    parameter int LAT_OP1 = DEF_LAT_OP1,
    parameter int LAT_OP2 = DEF_LAT_OP2,
    parameter int LAT_OP3 = DEF_LAT_OP3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instr_flat_in,
    input  logic [3:0]  valid_in,
    output logic [3:0]  retire_onehot,
    output logic        issue_valid,
    output logic [1:0]  issue_slot,
    output logic [7:0]  issue_instr,
    output logic        busy
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [15:0] issued_cnt,
    output logic [15:0] stall_cnt
`endif
);

    if (LAT_OP0 < 1 || LAT_OP0 > 15 || LAT_OP1 < 1 || LAT_OP1 > 15 ||
        LAT_OP2 < 1 || LAT_OP2 > 15 || LAT_OP3 < 1 || LAT_OP3 > 15) begin : g_bad_lat
        $error("instr_issue_scheduler: every LAT_OPx must lie in 1..15");
    end

    sched_state_e                          r_state;
    logic [NUM_SLOTS-1:0]                  r_valid_q;
    logic [NUM_SLOTS-1:0][NUM_SLOTS-1:0]   r_older;
    logic [3:0]                            r_cnt;
    logic [1:0]                            r_slot;
    logic [7:0]                            r_instr;
    logic                                  r_issue_valid;
    logic [3:0]                            r_retire;

    logic [NUM_SLOTS-1:0] w_tracked, w_new, w_inflight, w_blocked, w_ready, w_pick;
    logic [1:0]           w_pick_slot;
    logic                 w_pick_any;
    logic [7:0]           w_pick_instr;
    logic [3:0]           w_pick_lat;

    assign w_tracked  = valid_in & r_valid_q;
    assign w_new      = valid_in & ~r_valid_q;
    assign w_inflight = (r_state != IDLE) ? (4'b0001 << r_slot) : 4'b0000;
    assign w_ready    = w_tracked & ~w_blocked & ~w_inflight;

    sched_hazard_check u_hazard (
        .i_instr_flat (instr_flat_in),
        .i_tracked    (w_tracked),
        .i_older      (r_older),
        .o_blocked    (w_blocked)
    );

    always_comb begin
        w_pick      = '0;
        w_pick_slot = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_pick[i] = w_ready[i] & ~|(w_ready & r_older[i]);
        end
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (w_pick[i]) w_pick_slot = 2'(i);
        end
        w_pick_any   = |w_pick;
        w_pick_instr = instr_flat_in[8*w_pick_slot +: 8];
        case (w_pick_instr[OP_LO +: 2])
            2'b00:   w_pick_lat = 4'(LAT_OP0 - 1);
            2'b01:   w_pick_lat = 4'(LAT_OP1 - 1);
            2'b10:   w_pick_lat = 4'(LAT_OP2 - 1);
            default: w_pick_lat = 4'(LAT_OP3 - 1);
        endcase
    end

    // Age matrix: a newcomer is younger than everything already tracked, and simultaneous
    // newcomers are ordered by index; any slot leaving the queue loses its row and column.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid_q <= '0;
            r_older   <= '0;
        end else begin
            r_valid_q <= valid_in;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                for (int j = 0; j < NUM_SLOTS; j++) begin
                    if (i == j || !(valid_in[i] && valid_in[j])) begin
                        r_older[i][j] <= 1'b0;
                    end else if (w_new[i]) begin
                        r_older[i][j] <= r_valid_q[j] | (w_new[j] && (j < i));
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_slot        <= '0;
            r_instr       <= '0;
            r_issue_valid <= 1'b0;
            r_retire      <= '0;
        end else begin
            r_issue_valid <= 1'b0;
            r_retire      <= '0;
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_slot        <= w_pick_slot;
                        r_instr       <= w_pick_instr;
                        r_cnt         <= w_pick_lat;
                        r_issue_valid <= 1'b1;
                        r_state       <= EXEC;
                    end
                end
                EXEC: begin
                    // The queue withdrew the in-flight entry, so drop it without retiring.
                    if (!valid_in[r_slot]) begin
                        r_state <= IDLE;
                    end else if (r_cnt == 4'd0) begin
                        r_retire <= 4'b0001 << r_slot;
                        r_state  <= RETIRE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RETIRE:  r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign retire_onehot = r_retire;
    assign issue_valid   = r_issue_valid;
    assign issue_slot    = r_slot;
    assign issue_instr   = r_instr;
    assign busy          = (r_state != IDLE);

`ifdef SCHED_PERF_CNT_EN
    logic [15:0] r_issued_cnt, r_stall_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_issued_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (r_issue_valid && r_issued_cnt != 16'hFFFF) r_issued_cnt <= r_issued_cnt + 16'd1;
            if (r_state == IDLE && |w_tracked && !(|w_ready) && r_stall_cnt != 16'hFFFF)
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign issued_cnt = r_issued_cnt;
    assign stall_cnt  = r_stall_cnt;
`endif

endmodule

// File: tb/tb_instr_issue_scheduler.sv
// Directed self-checking bench for instr_issue_scheduler (default latencies 1,1,2,4).
module tb_instr_issue_scheduler;

    logic        clk;
    logic        reset_n;
    logic [31:0] instr_flat_in;
    logic [3:0]  valid_in;
    logic [3:0]  retire_onehot;
    logic        issue_valid;
    logic [1:0]  issue_slot;
    logic [7:0]  issue_instr;
    logic        busy;
`ifdef SCHED_PERF_CNT_EN
    logic [15:0] issued_cnt;
    logic [15:0] stall_cnt;
`endif

    int checkCount = 0;
    int errorCount = 0;

    instr_issue_scheduler dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .instr_flat_in (instr_flat_in),
        .valid_in      (valid_in),
        .retire_onehot (retire_onehot),
        .issue_valid   (issue_valid),
        .issue_slot    (issue_slot),
        .issue_instr   (issue_instr),
        .busy          (busy)
`ifdef SCHED_PERF_CNT_EN
        ,
        .issued_cnt    (issued_cnt),
        .stall_cnt     (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] flat);
        valid_in      = valid;
        instr_flat_in = flat;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        applyStimulus(4'b0000, 32'h0);
        step();
        step();
        reset_n = 1'b1;
    endtask

    // Waits for the issue and retire of one slot, then withdraws it like the queue would.
    task automatic runOne(input logic [1:0] expSlot, input string tag);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            if (issue_valid) seen = 1'b1;
        end
        checkOutput({tag, " issued"}, 32'(seen), 32'd1);
        checkOutput({tag, " issue_slot"}, 32'(issue_slot), 32'(expSlot));
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            if (retire_onehot != 4'b0000) seen = 1'b1;
        end
        checkOutput({tag, " retire"}, 32'(retire_onehot), 32'(4'b0001 << expSlot));
        applyStimulus(valid_in & ~(4'b0001 << expSlot), instr_flat_in);
    endtask

    initial begin
        reset_n = 1'b0;
        applyStimulus(4'hF, 32'h3F2A1500);

        // Reset with every slot valid, then the first issue two cycles after release.
        step();
        step();
        checkOutput("rst retire", 32'(retire_onehot), 32'h0);
        checkOutput("rst issue_valid", 32'(issue_valid), 32'h0);
        checkOutput("rst issue_slot", 32'(issue_slot), 32'h0);
        checkOutput("rst issue_instr", 32'(issue_instr), 32'h0);
        checkOutput("rst busy", 32'(busy), 32'h0);
        reset_n = 1'b1;
        step();
        checkOutput("rel+1 issue_valid", 32'(issue_valid), 32'h0);
        step();
        checkOutput("rel+2 issue_valid", 32'(issue_valid), 32'h1);
        checkOutput("rel+2 issue_slot", 32'(issue_slot), 32'h0);

        // Single LAT=1 instruction: issue at t+2, one-cycle retire at t+3.
        doReset();
        step();
        applyStimulus(4'b0001, 32'h0000001B);
        step();
        checkOutput("single t+1 issue_valid", 32'(issue_valid), 32'h0);
        step();
        checkOutput("single t+2 issue_valid", 32'(issue_valid), 32'h1);
        checkOutput("single t+2 issue_instr", 32'(issue_instr), 32'h1B);
        checkOutput("single t+2 busy", 32'(busy), 32'h1);
        checkOutput("single t+2 retire", 32'(retire_onehot), 32'h0);
        step();
        checkOutput("single t+3 retire", 32'(retire_onehot), 32'h1);
        checkOutput("single t+3 issue_valid", 32'(issue_valid), 32'h0);
        applyStimulus(4'b0000, instr_flat_in);
        step();
        checkOutput("single t+4 retire", 32'(retire_onehot), 32'h0);
        checkOutput("single t+4 busy", 32'(busy), 32'h0);
        step();
        checkOutput("single t+5 issue_valid", 32'(issue_valid), 32'h0);

        // RAW pair: slot1 reads slot0's destination and must wait for its retire.
        doReset();
        step();
        applyStimulus(4'b0001, 32'h000000C1);
        step();
        applyStimulus(4'b0011, 32'h000012C1);
        step();
        checkOutput("raw t+2 issue_valid", 32'(issue_valid), 32'h1);
        checkOutput("raw t+2 issue_slot", 32'(issue_slot), 32'h0);
        checkOutput("raw t+2 issue_instr", 32'(issue_instr), 32'hC1);
        for (int k = 3; k <= 5; k++) begin
            step();
            checkOutput($sformatf("raw t+%0d issue_valid", k), 32'(issue_valid), 32'h0);
            checkOutput($sformatf("raw t+%0d retire", k), 32'(retire_onehot), 32'h0);
        end
        step();
        checkOutput("raw t+6 retire", 32'(retire_onehot), 32'h1);
        checkOutput("raw t+6 issue_valid", 32'(issue_valid), 32'h0);
        applyStimulus(4'b0010, instr_flat_in);
        step();
        checkOutput("raw t+7 busy", 32'(busy), 32'h0);
        checkOutput("raw t+7 issue_valid", 32'(issue_valid), 32'h0);
        step();
        checkOutput("raw t+8 issue_valid", 32'(issue_valid), 32'h1);
        checkOutput("raw t+8 issue_slot", 32'(issue_slot), 32'h1);
        checkOutput("raw t+8 issue_instr", 32'(issue_instr), 32'h12);
        step();
        checkOutput("raw t+9 retire", 32'(retire_onehot), 32'h2);
        applyStimulus(4'b0000, instr_flat_in);
        step();
`ifdef SCHED_PERF_CNT_EN
        checkOutput("perf issued_cnt", 32'(issued_cnt), 32'd2);
        checkOutput("perf stall_cnt", 32'(stall_cnt), 32'd0);
`endif

        // Age beats index: slot0 refilled after retiring goes to the back of the line.
        doReset();
        step();
        applyStimulus(4'b1111, 32'h3F2A1500);
        runOne(2'd0, "age first");
        step();
        applyStimulus(valid_in | 4'b0001, instr_flat_in);
        runOne(2'd1, "age second");
        runOne(2'd2, "age third");
        runOne(2'd3, "age fourth");
        step();
        checkOutput("age drained busy", 32'(busy), 32'h0);

        // Abort: the queue withdraws the in-flight LAT=4 entry mid-EXEC.
        doReset();
        step();
        applyStimulus(4'b0100, 32'h00C00000);
        step();
        step();
        checkOutput("abort issue_slot", 32'(issue_slot), 32'h2);
        checkOutput("abort issue_valid", 32'(issue_valid), 32'h1);
        step();
        applyStimulus(4'b0000, instr_flat_in);
        step();
        checkOutput("abort busy", 32'(busy), 32'h0);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("abort retire %0d", k), 32'(retire_onehot), 32'h0);
            step();
        end

        // Reset during EXEC: immediate return to zero, then the survivor re-issues as new.
        doReset();
        step();
        applyStimulus(4'b0001, 32'h000000C1);
        step();
        step();
        step();
        checkOutput("midrst busy before", 32'(busy), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst busy", 32'(busy), 32'h0);
        checkOutput("midrst retire", 32'(retire_onehot), 32'h0);
        checkOutput("midrst issue_instr", 32'(issue_instr), 32'h0);
        step();
        reset_n = 1'b1;
        step();
        checkOutput("midrst rel+1 issue_valid", 32'(issue_valid), 32'h0);
        step();
        checkOutput("midrst rel+2 issue_valid", 32'(issue_valid), 32'h1);
        checkOutput("midrst rel+2 issue_instr", 32'(issue_instr), 32'hC1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/instr_issue_scheduler.md
Name: instr_issue_scheduler

Overview:
- Single-issue scheduler sitting beside the 4-entry instruction queue.
- Reads the queue window (packed instructions plus valid bits) and tracks the age of each slot.
- Picks the oldest hazard-free entry and runs it on one multi-cycle execution unit with an opcode-dependent latency.
- On completion, pulses a one-hot retire mask back to the queue.

Parameters:
- LAT_OP0, 1, execution cycles for opcode 2'b00 (legal range 1..15)
- LAT_OP1, 1, execution cycles for opcode 2'b01
- LAT_OP2, 2, execution cycles for opcode 2'b10
- LAT_OP3, 4, execution cycles for opcode 2'b11

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- instr_flat_in  in  32  queue window; slot k occupies [8k+7:8k] as {op[7:6], src1[5:4], src2[3:2], dest[1:0]}
- valid_in  in  4  per-slot valid bits from the queue
- retire_onehot  out  4  registered one-cycle pulse naming the retired slot
- issue_valid  out  1  registered one-cycle pulse when an instruction issues
- issue_slot  out  2  slot of the issued or in-flight instruction
- issue_instr  out  8  copy of the issued instruction
- busy  out  1  high while state is not IDLE

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; all outputs 0.
  - tracked mask valid_q=0; age matrix cleared; latency counter 0.
- Slot tracking:
  - A new entry in slot i is valid_in[i] & ~valid_q[i]. On that edge, older[i][j] <= valid_q[j] for all j≠i.
  - If several slots are new on the same edge, the lower index is treated as older.
  - valid_q <= valid_in every cycle.
  - A slot may be issued only when valid_in & valid_q is set, so there is one cycle of tracking latency.
- Hazards: a tracked slot i is blocked if any tracked slot j with older[i][j]=1 has any of:
  - RAW: dest_j matches src1_i or src2_i
  - WAW: dest_j == dest_i
  - WAR: src1_j or src2_j matches dest_i
- ready[i] = tracked, not blocked, and not in flight.
- Pick: the oldest ready slot, i.e. the ready slot with no older ready slot.
- FSM:
  - IDLE: if any slot is ready, latch slot and instruction, load cnt=LAT_OPx-1, pulse issue_valid the next cycle, go to EXEC.
  - EXEC: if cnt==0 go to RETIRE; otherwise decrement.
  - RETIRE: retire_onehot=1<<slot for exactly one cycle, then go to IDLE. The issue decision in IDLE is taken no earlier than the following cycle.
- Latency: issue_valid to retire_onehot is LAT cycles, so a LAT=1 instruction issues at t+2 and retires at t+3 relative to valid_in rising at t.
- At most one instruction is in flight; busy=1 in EXEC and RETIRE.
- The queue never reuses a retiring slot on the retire edge, so no retire/enqueue collision is possible on the same slot.
- Abort: if valid_in[slot] drops while in EXEC (queue reset):
  - go to IDLE next edge with no retire pulse;
  - clear that slot's age row and column.
- Any slot whose valid_in drops clears its age row and column.
- Reset mid-EXEC: immediate IDLE, no retire. Entries still valid afterward are treated as new, with index-order tiebreak.
- Widths: cnt is 4 bits; LAT of 0 or above 15 is illegal and checked by an elaboration assertion.

Optional Feature:
- Macro: SCHED_PERF_CNT_EN.
- When defined, two extra outputs:
  - issued_cnt[15:0]: increments on issue_valid.
  - stall_cnt[15:0]: increments on cycles where state=IDLE, (valid_in & valid_q)!=0 and no slot is ready.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package sched_pkg:
  - field slice constants (OP/SRC1/SRC2/DEST bit positions);
  - FSM state enum {IDLE, EXEC, RETIRE};
  - default latency constants;
  - NUM_SLOTS=4.
- Sub-module sched_hazard_check: combinational. Takes instructions, tracked mask and age matrix; returns the 4-bit blocked vector.

Test Plan:
- Reset: hold reset_n=0 with valid_in=4'hF → all outputs 0. Release → first issue_valid two cycles later with issue_slot=0.
- Single instruction 8'h1B in slot 0 (valid_in 0000→0001 at t, LAT=1) → issue_valid at t+2, issue_instr=8'h1B, retire_onehot=4'b0001 at t+3 only.
- RAW ordering: slot0=8'hC1 (op3, dest1, LAT=4), then slot1=8'h12 (src1=1):
  - slot1 never issues before slot0 retires;
  - 4 cycles from issue_valid to retire_onehot=0001;
  - slot1 issues the cycle after IDLE is re-entered.
- Age vs index: fill slots 0-3 with independent instructions (8'h00, 8'h15, 8'h2A, 8'h3F), retire slot 0, enqueue 8'h00 into slot 0 → issue order 1, 2, 3, 0.
- Abort: drop valid_in[issue_slot] mid-EXEC of a LAT=4 opcode → no retire pulse, busy=0 next cycle.
- Reset mid-op: assert reset_n=0 during EXEC → outputs 0 immediately, no retire. With SCHED_PERF_CNT_EN, issued_cnt and stall_cnt are checked after a blocked RAW pair.
